fsmc_fifo_bridge: RTL
=====================

Name: fsmc_fifo_bridge

Overview:
- Peripheral slave directly downstream of the FSMC bus interface.
- Consumes the interface's captured address/data word, chip-select address and chip-select enable pulse.
- Returns read data and a selected flag to the interface.
- Bridges one chip-select window to a TX FIFO (bus→fabric stream) and an RX FIFO (fabric→bus stream), plus status and control registers.

Parameters:
- CS_ID, 3'd1, chip-select address this instance answers to.
- DEPTH, 16, entries per FIFO; power of two, 2..16.
- WIDTH, 16, data width; fixed to the bus word width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- module_in  in  16  captured bus word: address phase, then write data.
- cs_addr_latch  in  3  captured chip-select address.
- en_cs  in  1  high from address capture until write-data capture or read end.
- module_out  out  16  read data presented to the bus interface.
- cs_state  out  1  1 = this instance selected for the current access.
- tx_data  out  16  TX stream data (FIFO head).
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  fabric accepts tx_data this cycle.
- rx_data  in  16  RX stream data.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- Reset values: module_out=0, cs_state=0, both FIFOs empty (tx_valid=0, rx_ready=1), sticky flags=0, FSM=IDLE. Reset mid-access aborts the access with no push or pop.
- en_cs rise/fall are detected against a one-cycle delayed copy.
- Register map uses module_in[1:0] latched at the en_cs rise:
  - 0: TXDATA, write-only.
  - 1: RXDATA, read-only, pops.
  - 2: STATUS, read-only.
  - 3: CTRL, write-only.
- Direction is implied by the address; no separate read/write strobe.
- FSM IDLE:
  - On en_cs rise with cs_addr_latch==CS_ID: latch reg index, go to SEL.
  - On en_cs rise with a mismatched chip select: stay in IDLE, cs_state=0, module_out=0.
- FSM SEL:
  - cs_state=1 from the cycle after the en_cs rise.
  - module_out is registered every cycle from the RX head (index 1), STATUS (index 2), or 0 (indices 0/3).
  - On en_cs fall: go to COMMIT.
- FSM COMMIT (one cycle), by latched index:
  - 0: push module_in into TX. If full, drop the word and set tx_ovf.
  - 1: pop RX. If empty, set rx_udf; the read already returned 0x0000.
  - 2: clear tx_ovf and rx_udf (read-to-clear).
  - 3: bit0=1 flushes TX, bit1=1 flushes RX; other bits ignored.
  - Then cs_state=0 and go to IDLE.
- STATUS word:
  - [4:0] tx_level, [9:5] rx_level.
  - [10] tx_full, [11] rx_empty.
  - [12] tx_ovf, [13] rx_udf.
  - [15:14] = 0.
- Stream handshakes:
  - TX pops when tx_valid & tx_ready.
  - RX pushes when rx_valid & rx_ready.
  - Bus and stream ops in the same cycle are legal; levels update by the net change, and a full FIFO with a simultaneous pop accepts the push.
  - A flush has priority over a same-cycle stream push/pop: the FIFO ends empty.
- Pointers wrap modulo DEPTH. Level width is clog2(DEPTH)+1.
- A new en_cs rise cannot occur in SEL (en_cs must fall first). An en_cs rise during COMMIT is handled on the next IDLE cycle, because COMMIT delays the rise detection by one cycle via a pending bit.

Optional Feature:
- FSMC_FIFO_IRQ_EN.
- Defined:
  - Adds input irq_thresh[4:0] and output irq.
  - irq is registered; it is high when rx_level >= irq_thresh (and irq_thresh != 0), OR tx_ovf OR rx_udf.
  - Reset value is 0.
- Undefined: neither port exists; no irq logic is generated.

Decomposition:
- Shared package fsmc_pkg:
  - reg index constants (REG_TXDATA..REG_CTRL).
  - STATUS bit-position constants.
  - FSM state enum {IDLE, SEL, COMMIT}.
  - CTRL flush bit constants.
- Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice:
  - ports: push, pop, flush, din, dout, level, full, empty.
  - first-word-fall-through.

Test Plan:
- Write burst: address 0x0008 (cs=1, idx0), write 0x1234, 0xBEEF with tx_ready=0 → tx_level=2, tx_data=0x1234; raise tx_ready for 2 cycles → tx_valid=0.
- Overflow: 17 TX writes with tx_ready=0 → level stays 16, STATUS[12]=1, 17th word absent; a STATUS read then clears it (next read shows bit 12 = 0).
- RX read: push 0xA5A5 via rx_valid, read idx1 → module_out=0xA5A5 while cs_state=1, then rx_level=0; a further read → 0x0000 and rx_udf=1.
- Foreign select: cs_addr_latch=3'd2 with en_cs pulse and write 0x5555 → cs_state stays 0, module_out=0, no FIFO change.
- Simultaneous ops: TX full, bus write 0x7777 in the same cycle as a tx_ready pop → level stays 16, no tx_ovf, 0x7777 at the tail.
- Reset mid-SEL: assert reset between the en_cs rise and fall → cs_state=0, no push occurs, FIFOs empty, FSM IDLE.

Source files
------------

// File: rtl/fsmc_pkg.sv
// fsmc_pkg: shared definitions for the FSMC FIFO bridge.
//   - register index constants (decoded from address bits [1:0])
//   - STATUS word bit positions and a packing helper
//   - CTRL flush bit positions
//   - bridge FSM state enum
package fsmc_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_LEVEL_LSB = 0;
  localparam int ST_RX_LEVEL_LSB = 5;
  localparam int ST_TX_FULL      = 10;
  localparam int ST_RX_EMPTY     = 11;
  localparam int ST_TX_OVF       = 12;
  localparam int ST_RX_UDF       = 13;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEL    = 2'd1,
    COMMIT = 2'd2
  } fsm_state_t;

  function automatic logic [15:0] pack_status(
    input logic [4:0] tx_lvl,
    input logic [4:0] rx_lvl,
    input logic       tx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_udf
  );
    logic [15:0] w;
    w = '0;
    w[ST_TX_LEVEL_LSB +: 5] = tx_lvl;
    w[ST_RX_LEVEL_LSB +: 5] = rx_lvl;
    w[ST_TX_FULL]           = tx_full;
    w[ST_RX_EMPTY]          = rx_empty;
    w[ST_TX_OVF]            = tx_ovf;
    w[ST_RX_UDF]            = rx_udf;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
// Ports:
//   clk, reset      clock, asynchronous active-high reset (pointers/count only)
//   push, din       write request and data; accepted when not full, or when
//                   full with an effective pop in the same cycle
//   pop             read request; ignored when empty
//   flush           empties the FIFO, overriding any same-cycle push/pop
//   dout            current head word (valid while !empty)
//   level           number of stored words, $clog2(DEPTH)+1 bits
//   full, empty     occupancy flags
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             do_pop;
  logic             do_push;

  assign full    = (cnt == LW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsmc_fifo_bridge.sv
// fsmc_fifo_bridge: FSMC chip-select slave bridging one window to a TX
// stream FIFO (bus -> fabric) and an RX stream FIFO (fabric -> bus).
// Register index = module_in[1:0] at the en_cs rise:
//   0 TXDATA (wo, push), 1 RXDATA (ro, pop), 2 STATUS (ro, read-to-clear
//   sticky flags), 3 CTRL (wo, bit0 flush TX, bit1 flush RX).
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   module_in           captured bus word (address phase, then write data)
//   cs_addr_latch       captured chip-select address
//   en_cs               access enable from the bus interface
//   module_out          registered read data
//   cs_state            this instance selected for the current access
//   tx_data/valid/ready TX stream (FIFO head)
//   rx_data/valid/ready RX stream
// Optional macro FSMC_FIFO_IRQ_EN adds irq_thresh[4:0] input and registered
// irq output (rx_level >= irq_thresh when thresh != 0, or any sticky flag).
module fsmc_fifo_bridge
  import fsmc_pkg::*;
#(
  parameter logic [2:0] CS_ID = 3'd1,
  parameter int         DEPTH = 16,
  parameter int         WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] module_in,
  input  logic [2:0]  cs_addr_latch,
  input  logic        en_cs,
  output logic [15:0] module_out,
  output logic        cs_state,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef FSMC_FIFO_IRQ_EN
  ,
  input  logic [4:0]  irq_thresh,
  output logic        irq
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  fsm_state_t state, state_n;

  logic             en_d;
  logic             rise;
  logic             fall;
  logic [1:0]       idx_q;
  logic             pend;
  logic [1:0]       pend_idx;
  logic             pend_hit;
  logic             start_req;
  logic             start_hit;
  logic [1:0]       start_idx;
  logic [1:0]       sel_idx;
  logic             tx_ovf;
  logic             rx_udf;

  logic             tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic             clr_flags;
  logic [LW-1:0]    tx_level, rx_level;
  logic [WIDTH-1:0] tx_dout, rx_dout;
  logic [15:0]      status_w;
  logic [15:0]      read_mux;

  assign rise = en_cs & ~en_d;
  assign fall = ~en_cs & en_d;

  // A rise seen during COMMIT is parked in pend and serviced from IDLE.
  assign start_req = rise | pend;
  assign start_hit = rise ? (cs_addr_latch == CS_ID) : pend_hit;
  assign start_idx = rise ? module_in[1:0] : pend_idx;
  assign sel_idx   = (state == IDLE) ? start_idx : idx_q;

  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;
  assign tx_valid = ~tx_empty;
  assign tx_data  = tx_dout;
  assign rx_ready = ~rx_full;

  assign status_w = pack_status(5'(tx_level), 5'(rx_level), tx_full, rx_empty,
                                tx_ovf, rx_udf);

  always_comb begin
    read_mux = '0;
    case (sel_idx)
      REG_RXDATA: read_mux = rx_empty ? 16'h0000 : rx_dout;
      REG_STATUS: read_mux = status_w;
      default:    read_mux = '0;
    endcase
  end

  always_comb begin
    state_n   = state;
    tx_push   = 1'b0;
    rx_pop    = 1'b0;
    clr_flags = 1'b0;
    tx_flush  = 1'b0;
    rx_flush  = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && start_hit) state_n = SEL;
      end
      SEL: begin
        if (fall) state_n = COMMIT;
      end
      COMMIT: begin
        state_n = IDLE;
        case (idx_q)
          REG_TXDATA: tx_push   = 1'b1;
          REG_RXDATA: rx_pop    = 1'b1;
          REG_STATUS: clr_flags = 1'b1;
          default: begin
            tx_flush = module_in[CTRL_FLUSH_TX];
            rx_flush = module_in[CTRL_FLUSH_RX];
          end
        endcase
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      en_d  <= 1'b0;
    end else begin
      state <= state_n;
      en_d  <= en_cs;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      pend     <= 1'b0;
      pend_idx <= '0;
      pend_hit <= 1'b0;
    end else begin
      if (state == IDLE && start_req) idx_q <= start_idx;
      if (state == COMMIT && rise) begin
        pend     <= 1'b1;
        pend_idx <= module_in[1:0];
        pend_hit <= (cs_addr_latch == CS_ID);
      end else if (state == IDLE) begin
        pend <= 1'b0;
      end
    end
  end

  // Sticky error flags, cleared by a STATUS read commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else if (clr_flags) begin
      tx_ovf <= 1'b0;
      rx_udf <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
      if (rx_pop && rx_empty)            rx_udf <= 1'b1;
    end
  end

  // Read data refreshes while selected, holds through COMMIT, 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      module_out <= '0;
      cs_state   <= 1'b0;
    end else begin
      cs_state <= (state_n == SEL) || (state_n == COMMIT);
      case (state_n)
        SEL:     module_out <= read_mux;
        COMMIT:  module_out <= module_out;
        default: module_out <= '0;
      endcase
    end
  end

`ifdef FSMC_FIFO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else irq <= ((irq_thresh != 5'd0) && (5'(rx_level) >= irq_thresh)) ||
                tx_ovf || rx_udf;
  end
`endif

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (module_in),
    .dout  (tx_dout),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (rx_data),
    .dout  (rx_dout),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule
